l80_uart_io_hub: RTL

//  Parametrised light8080 IO-space UART hub: NCH UART channels, each with an RX FIFO and a
//  1-entry TX holding register, behind a decoded IO register window at BASE_ADDR.

---
 rtl/l80_uart_io_hub_pkg.sv | 51 +++++
 rtl/l80_byte_fifo.sv | 50 +++++
 rtl/l80_uart_io_hub.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/l80_uart_io_hub_pkg.sv
// l80_uart_io_hub_pkg
//   Shared definitions for the light8080 IO-space UART hub:
//   register offsets inside a channel pair, STAT bit positions,
//   IRQEN bit formula and the STAT packing helper.
package l80_uart_io_hub_pkg;

  // Offsets within a channel's two-register slot
  localparam int OFS_DATA = 0;
  localparam int OFS_STAT = 1;

  // STAT bit positions (bits 4 and 0 match the legacy USTAT layout)
  localparam int STAT_OVR  = 6;
  localparam int STAT_FULL = 5;
  localparam int STAT_NE   = 4;
  localparam int STAT_TXP  = 1;
  localparam int STAT_TXB  = 0;

  typedef struct packed {
    logic ovr;
    logic full;
    logic ne;
    logic txp;
    logic txb;
  } ch_stat_t;

  function automatic logic [7:0] pack_stat(ch_stat_t s);
    logic [7:0] r;
    r            = 8'h00;
    r[STAT_OVR]  = s.ovr;
    r[STAT_FULL] = s.full;
    r[STAT_NE]   = s.ne;
    r[STAT_TXP]  = s.txp;
    r[STAT_TXB]  = s.txb | s.txp;
    return r;
  endfunction

  // IO address of register ofs in channel slot ch; slot NCH holds IRQEN
  function automatic logic [7:0] reg_addr(logic [7:0] base, int ch, int ofs);
    return base + 8'(2 * ch + ofs);
  endfunction

  // IRQEN bit indices for channel ch
  function automatic int irqen_rx_bit(int ch);
    return 2 * ch;
  endfunction

  function automatic int irqen_tx_bit(int ch);
    return 2 * ch + 1;
  endfunction

endpackage

// File: rtl/l80_byte_fifo.sv
// l80_byte_fifo
//   Byte FIFO, DEPTH a power of 2. Pointers carry one extra bit so
//   full/empty are told apart by wrap rather than a counter.
//   Pop when empty is ignored; push when full is accepted only if a
//   pop happens in the same cycle.
// Ports:
//   clock, reset      CPU clock, synchronous active-high reset
//   push, din         write strobe and byte
//   pop               read strobe
//   full, empty       occupancy flags
//   head              oldest byte, 8'h00 when empty
module l80_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/l80_uart_io_hub.sv
// l80_uart_io_hub
//   light8080 IO-space hub for NCH UART channels. Each channel has an
//   RX FIFO and a one-entry TX holding register behind DATA/STAT
//   registers at BASE_ADDR+2*ch / +2*ch+1; IRQEN sits at BASE_ADDR+2*NCH.
//   Build option: define L80_IO_IRQ_EN for a R/W IRQEN register and a
//   live irq; otherwise IRQEN reads 0 and irq is tied low.
// Ports:
//   clock, reset                  CPU clock, synchronous active-high reset
//   cpu_io/rd/wr/addr/dout        CPU IO bus
//   io_dout                       registered read data
//   rx_valid, rx_data             per-channel received-byte pulse/byte
//   tx_valid, tx_data, tx_busy    per-channel transmit handshake
//   irq                           level interrupt request
module l80_uart_io_hub
  import l80_uart_io_hub_pkg::*;
#(
  parameter int         NCH       = 2,
  parameter int         RX_DEPTH  = 4,
  parameter logic [7:0] BASE_ADDR = 8'h80
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpu_io,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [7:0]          cpu_addr,
  input  logic [7:0]          cpu_dout,
  output logic [7:0]          io_dout,
  input  logic [NCH-1:0]      rx_valid,
  input  logic [NCH-1:0][7:0] rx_data,
  output logic [NCH-1:0]      tx_valid,
  output logic [NCH-1:0][7:0] tx_data,
  input  logic [NCH-1:0]      tx_busy,
  output logic                irq
);

  logic [NCH-1:0][7:0] head;
  logic [NCH-1:0][7:0] stat;
  logic [NCH-1:0]      rx_ne, tx_pend;
  logic [7:0]          irqen_rd;
  logic [7:0]          rd_val;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic       hit_data, hit_stat;
    logic       rd_data, rd_stat, wr_data;
    logic       rd_data_q, rd_stat_q, wr_data_q;
    logic       pop, wr_edge, full, empty, ovr, ovr_set, pend;
    logic [7:0] txd;

    assign hit_data = cpu_io & (cpu_addr == reg_addr(BASE_ADDR, c, OFS_DATA));
    assign hit_stat = cpu_io & (cpu_addr == reg_addr(BASE_ADDR, c, OFS_STAT));
    assign rd_data  = hit_data & cpu_rd;
    assign rd_stat  = hit_stat & cpu_rd;
    assign wr_data  = hit_data & cpu_wr;
    // One pop / one latch per strobe, however long rd/wr is held
    assign pop      = rd_data & ~rd_data_q;
    assign wr_edge  = wr_data & ~wr_data_q;
    // full implies non-empty, so a pop here always frees a slot
    assign ovr_set  = rx_valid[c] & full & ~pop;

    l80_byte_fifo #(.DEPTH(RX_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rx_valid[c]),
      .din   (rx_data[c]),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head[c])
    );

    always_ff @(posedge clock) begin
      if (reset) begin
        rd_data_q <= 1'b0;
        rd_stat_q <= 1'b0;
        wr_data_q <= 1'b0;
        ovr       <= 1'b0;
        pend      <= 1'b0;
        txd       <= 8'h00;
      end else begin
        rd_data_q <= rd_data;
        rd_stat_q <= rd_stat;
        wr_data_q <= wr_data;
        // Clear lands the cycle after the STAT read; a new overrun wins
        ovr       <= ovr_set | (ovr & ~rd_stat_q);
        if (pend & ~tx_busy[c])
          pend <= 1'b0;
        else if (wr_edge & ~pend) begin
          pend <= 1'b1;
          txd  <= cpu_dout;
        end
      end
    end

    assign tx_valid[c] = pend & ~tx_busy[c];
    assign tx_data[c]  = txd;
    assign rx_ne[c]    = ~empty;
    assign tx_pend[c]  = pend;
    assign stat[c]     = pack_stat('{ovr: ovr, full: full, ne: ~empty,
                                      txp: pend, txb: tx_busy[c]});
  end

  always_comb begin
    rd_val = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (cpu_addr == reg_addr(BASE_ADDR, c, OFS_DATA)) rd_val = head[c];
      if (cpu_addr == reg_addr(BASE_ADDR, c, OFS_STAT)) rd_val = stat[c];
    end
    if (cpu_addr == reg_addr(BASE_ADDR, NCH, 0)) rd_val = irqen_rd;
  end

  always_ff @(posedge clock) begin
    if (reset)       io_dout <= 8'h00;
    else if (cpu_io) io_dout <= rd_val;
  end

`ifdef L80_IO_IRQ_EN
  logic [7:0]       irqen;
  logic [2*NCH-1:0] irq_src;

  always_comb begin
    irq_src = '0;
    for (int c = 0; c < NCH; c++) begin
      irq_src[irqen_rx_bit(c)] = rx_ne[c];
      irq_src[irqen_tx_bit(c)] = ~tx_pend[c] & ~tx_busy[c];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irqen <= 8'h00;
      irq   <= 1'b0;
    end else begin
      if (cpu_io & cpu_wr & (cpu_addr == reg_addr(BASE_ADDR, NCH, 0)))
        irqen <= cpu_dout;
      irq <= |(irq_src & irqen[2*NCH-1:0]);
    end
  end

  assign irqen_rd = irqen;
`else
  // No interrupt sources without the option; status bits only feed STAT
  assign irqen_rd = 8'h00;
  assign irq      = 1'b0;
`endif

endmodule
